// File: rtl/ghost_pkg.sv
// ----------------------------------------------------------------------------
// ghost_pkg
// Shared types and helpers for the ghost motion controller.
//   - coord_t / pos_t : 5-bit tile coordinates and an (x, y) pair
//   - dir_t           : one-hot direction {down, up, right, left}, 0 = none
//   - state_t         : motion controller states (SCAN, WAIT)
//   - neighbour()     : tile one step away in a direction (5-bit wrap)
//   - off_grid()      : true when that step would leave the 0..31 grid
//   - scan_dir()      : read-order index (0..3) to direction
//   - is_onehot()     : exactly one bit of a direction set
// ----------------------------------------------------------------------------
package ghost_pkg;

   localparam int COORD_W = 5;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [3:0]         dir_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
   } pos_t;

   localparam coord_t COORD_MAX = '1;

   localparam dir_t DIR_NONE  = 4'b0000;
   localparam dir_t DIR_LEFT  = 4'b0001;
   localparam dir_t DIR_RIGHT = 4'b0010;
   localparam dir_t DIR_UP    = 4'b0100;
   localparam dir_t DIR_DOWN  = 4'b1000;

   typedef enum logic {
      SCAN,
      WAIT
   } state_t;

   // Up is y-1, down is y+1. Arithmetic is modulo 32, which is exactly the
   // tunnel behaviour; the non-tunnel build masks edge moves via off_grid().
   function automatic pos_t neighbour(input pos_t p, input dir_t d);
      pos_t n;
      n = p;
      case (d)
         DIR_LEFT:  n.x = p.x - coord_t'(1);
         DIR_RIGHT: n.x = p.x + coord_t'(1);
         DIR_UP:    n.y = p.y - coord_t'(1);
         DIR_DOWN:  n.y = p.y + coord_t'(1);
         default:   n = p;
      endcase
      return n;
   endfunction

   function automatic logic off_grid(input pos_t p, input dir_t d);
      logic r;
      case (d)
         DIR_LEFT:  r = (p.x == '0);
         DIR_RIGHT: r = (p.x == COORD_MAX);
         DIR_UP:    r = (p.y == '0);
         DIR_DOWN:  r = (p.y == COORD_MAX);
         default:   r = 1'b0;
      endcase
      return r;
   endfunction

   // Read order left, right, up, down matches the mask bit order, so the
   // index is simply the bit position.
   function automatic dir_t scan_dir(input logic [1:0] idx);
      return dir_t'(DIR_LEFT << idx);
   endfunction

   function automatic logic is_onehot(input dir_t d);
      return (d != DIR_NONE) && ((d & (d - dir_t'(1))) == DIR_NONE);
   endfunction

endpackage

// File: rtl/ghost_motion_ctrl_if.sv
// ----------------------------------------------------------------------------
// ghost_motion_ctrl_if
// Maze wall-map read port between the ghost controller and the maze ROM.
//   maze_rd_en   : read strobe (controller -> ROM)
//   maze_addr_x  : tile x being queried (controller -> ROM)
//   maze_addr_y  : tile y being queried (controller -> ROM)
//   maze_wall    : wall bit for the tile strobed on the previous cycle
//                  (ROM -> controller, 1 = blocked)
// Modports: master = ghost controller, slave = maze ROM.
// ----------------------------------------------------------------------------
interface ghost_motion_ctrl_if;
   import ghost_pkg::*;

   logic   maze_rd_en;
   coord_t maze_addr_x;
   coord_t maze_addr_y;
   logic   maze_wall;

   modport master (
      output maze_rd_en,
      output maze_addr_x,
      output maze_addr_y,
      input  maze_wall
   );

   modport slave (
      input  maze_rd_en,
      input  maze_addr_x,
      input  maze_addr_y,
      output maze_wall
   );

endinterface

// File: rtl/ghost_maze_scan.sv
// ----------------------------------------------------------------------------
// ghost_maze_scan
// Queries the four neighbours of the ghost (left, right, up, down) on four
// consecutive cycles while scan_en is high and assembles the open-direction
// mask from the one-cycle-late wall responses.
// Ports:
//   clk_25mhz, reset : clock, asynchronous active-low reset
//   scan_en          : controller is in SCAN; low clears the sequencer
//   pos              : current ghost tile (stable for the whole scan)
//   maze             : wall-map read port (master side)
//   mask             : {down, up, right, left} open bits, valid with done
//   done             : one-cycle pulse while the 4th response is on maze_wall
// Configuration: GHOST_TUNNEL_WRAP_EN defined lets neighbours wrap modulo 32;
// otherwise a neighbour off the grid is still read but reported blocked.
// ----------------------------------------------------------------------------
module ghost_maze_scan
   import ghost_pkg::*;
(
   input  logic                clk_25mhz,
   input  logic                reset,
   input  logic                scan_en,
   input  pos_t                pos,
   ghost_motion_ctrl_if.master maze,
   output dir_t                mask,
   output logic                done
);

   localparam logic [2:0] SCAN_READS = 3'd4;

   logic [2:0] issue_idx;
   logic       rd_en;
   pos_t       rd_addr;

   logic       rsp_due;    // a strobe went out last cycle; its answer is on maze_wall now
   logic [1:0] rsp_idx;
   logic [2:0] open_acc;   // {up, right, left} collected so far
   logic       open_bit;

   assign maze.maze_rd_en  = rd_en;
   assign maze.maze_addr_x = rd_addr.x;
   assign maze.maze_addr_y = rd_addr.y;

   // Read sequencer: one strobe per cycle, four in total, then idle until
   // the controller leaves SCAN and comes back.
   always_ff @(posedge clk_25mhz or negedge reset) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      if (!reset) begin
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         issue_idx <= '0;
      end else if (!scan_en) begin
         rd_en     <= 1'b0;
         issue_idx <= '0;
      end else if (issue_idx != SCAN_READS) begin
         rd_en     <= 1'b1;
         rd_addr   <= neighbour(pos, scan_dir(issue_idx[1:0]));
         issue_idx <= issue_idx + 3'd1;
      end else begin
         rd_en     <= 1'b0;
      end
   end

`ifdef GHOST_TUNNEL_WRAP_EN
   assign open_bit = ~maze.maze_wall;
`else
   dir_t rsp_dir;
   assign rsp_dir  = scan_dir(rsp_idx);
   // Off-grid neighbours were read to keep timing fixed; their answer is ignored.
   assign open_bit = ~maze.maze_wall & ~off_grid(pos, rsp_dir);
`endif

   // Response collector. Bits shift in from the top so after three responses
   // open_acc holds {up, right, left} and the 4th (down) completes the mask.
   always_ff @(posedge clk_25mhz or negedge reset) begin
      if (!reset) begin
         rsp_due  <= 1'b0;
         rsp_idx  <= '0;
         open_acc <= '0;
      end else if (!scan_en) begin
         rsp_due  <= 1'b0;
         rsp_idx  <= '0;
         open_acc <= '0;
      end else begin
         rsp_due <= rd_en;
         if (rsp_due) begin
            open_acc <= {open_bit, open_acc[2:1]};
            rsp_idx  <= rsp_idx + 2'd1;
         end
      end
   end

   assign done = scan_en & rsp_due & (rsp_idx == 2'd3);
   assign mask = {open_bit, open_acc};

endmodule

// File: rtl/ghost_motion_ctrl.sv
// ----------------------------------------------------------------------------
// ghost_motion_ctrl
// Moves one ghost one tile per game step. Scans the four neighbours through
// the maze read port, publishes the open-direction mask for the AI, then on
// a move_tick commits the AI's request (or keeps going, or stops).
// Parameters:
//   START_X, START_Y : tile loaded at reset (13, 11)
// Ports:
//   clk_25mhz, reset : clock, asynchronous active-low reset
//   move_tick        : one-cycle game-step pulse
//   GhostDirection   : AI request, one-hot {down, up, right, left}
//   maze             : wall-map read port (maze_rd_en/addr_x/addr_y/wall)
//   GhostPosition_x/y: current tile
//   validDirection   : open neighbours {down, up, right, left}
//   dir_valid        : validDirection is current for this position
//   GhostDirActual   : direction of the last committed move, 0 = stopped
// Configuration: GHOST_TUNNEL_WRAP_EN (see ghost_maze_scan) enables the side
// tunnel; position arithmetic is modulo 32 in both builds.
// ----------------------------------------------------------------------------
module ghost_motion_ctrl
   import ghost_pkg::*;
#(
   parameter coord_t START_X = 5'd13,
   parameter coord_t START_Y = 5'd11
) (
   input  logic                clk_25mhz,
   input  logic                reset,
   input  logic                move_tick,
   input  dir_t                GhostDirection,
   ghost_motion_ctrl_if.master maze,
   output coord_t              GhostPosition_x,
   output coord_t              GhostPosition_y,
   output dir_t                validDirection,
   output logic                dir_valid,
   output dir_t                GhostDirActual
);

   // Two cycles in WAIT let the AI register a request against the new mask.
   localparam logic [1:0] SETTLE_DONE = 2'd2;

   state_t     state_q,   state_d;
   logic [1:0] settle_q,  settle_d;
   logic       pending_q, pending_d;
   dir_t       mask_q,    mask_d;
   logic       valid_q,   valid_d;
   pos_t       pos_q,     pos_d;
   dir_t       act_q,     act_d;

   dir_t       scan_mask;
   logic       scan_done;

   logic       req_ok;
   logic       keep_ok;
   dir_t       move_dir;

   ghost_maze_scan u_scan (
      .clk_25mhz (clk_25mhz),
      .reset     (reset),
      .scan_en   (state_q == SCAN),
      .pos       (pos_q),
      .maze      (maze),
      .mask      (scan_mask),
      .done      (scan_done)
   );

   // Commit choice: a legal request wins, else keep the current heading if
   // it is still open, else stop. A multi-hot request is never legal.
   assign req_ok   = is_onehot(GhostDirection) && ((GhostDirection & mask_q) != DIR_NONE);
   assign keep_ok  = (act_q & mask_q) != DIR_NONE;
   assign move_dir = req_ok  ? GhostDirection :
                     keep_ok ? act_q          : DIR_NONE;

   always_ff @(posedge clk_25mhz or negedge reset) begin
      if (!reset) begin
         state_q   <= SCAN;
         settle_q  <= '0;
         pending_q <= 1'b0;
         mask_q    <= DIR_NONE;
         valid_q   <= 1'b0;
         pos_q     <= '{x: START_X, y: START_Y};
         act_q     <= DIR_NONE;
      end else begin
         state_q   <= state_d;
         settle_q  <= settle_d;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         valid_q   <= valid_d;
         pos_q     <= pos_d;
         act_q     <= act_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a hold-value default first, so
      // no path leaves one unassigned and no latch is inferred.
      state_d   = state_q;
      settle_d  = settle_q;
      pending_d = pending_q;
      mask_d    = mask_q;
      valid_d   = valid_q;
      pos_d     = pos_q;
      act_d     = act_q;

      case (state_q)
         SCAN: begin
            if (move_tick) begin
               pending_d = 1'b1;
            end
            if (scan_done) begin
               mask_d   = scan_mask;
               valid_d  = 1'b1;
               settle_d = '0;
               state_d  = WAIT;
            end
         end

         WAIT: begin
            if (settle_q != SETTLE_DONE) begin
               settle_d = settle_q + 2'd1;
               if (move_tick) begin
                  pending_d = 1'b1;
               end
            end else if (move_tick || pending_q) begin
               // A tick landing on the commit cycle is absorbed here.
               pos_d     = neighbour(pos_q, move_dir);
               act_d     = move_dir;
               pending_d = 1'b0;
               valid_d   = 1'b0;
               mask_d    = DIR_NONE;
               state_d   = SCAN;
            end
         end

         default: state_d = SCAN;
      endcase
   end

   assign GhostPosition_x = pos_q.x;
   assign GhostPosition_y = pos_q.y;
   assign validDirection  = mask_q;
   assign dir_valid       = valid_q;
   assign GhostDirActual  = act_q;

endmodule

// File: doc/ghost_motion_ctrl.md
# ghost_motion_ctrl

Moves one ghost through the maze one tile per game step, and produces the inputs its chase AI uses to pick a direction. The block scans the four neighbouring tiles through a maze wall-map read port and publishes a `validDirection` mask. It then accepts the AI's one-hot direction request on each `move_tick` and commits the move, reporting the new position and the direction actually taken. It sits between the maze ROM and the ghost AI, and feeds ghost position to the renderer and collision logic.

## Interface
- `START_X`, default 5'd13: tile x loaded at reset.
- `START_Y`, default 5'd11: tile y loaded at reset.
- `clk_25mhz` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `move_tick` input 1: one-cycle game-step pulse.
- `GhostDirection` input 4: direction requested by the AI, one-hot {down, up, right, left}.
- `maze_rd_en` output 1: wall-map read strobe.
- `maze_addr_x` output 5: tile x being queried.
- `maze_addr_y` output 5: tile y being queried.
- `maze_wall` input 1: wall bit for the tile queried on the previous cycle (1 = blocked).
- `GhostPosition_x` output 5: current tile x.
- `GhostPosition_y` output 5: current tile y.
- `validDirection` output 4: open neighbours {down, up, right, left}.
- `dir_valid` output 1: `validDirection` is current for the present position.
- `GhostDirActual` output 4: direction of the last committed move; 0 means stopped.

## Operation
- Encoding: left = 0001, right = 0010, up = 0100 (y−1), down = 1000 (y+1).
- Reset values: position = (START_X, START_Y); `validDirection`, `GhostDirActual`, `maze_rd_en`, `dir_valid` = 0; state = SCAN; tick-pending flag cleared.
- SCAN state: issues 4 reads on consecutive cycles in the order left, right, up, down.
  - Each response arrives 1 cycle after its strobe.
  - Each open bit is `~maze_wall`.
  - After the 4th response, `validDirection` is registered and `dir_valid` is set to 1. The state goes to WAIT.
- WAIT state: a settle counter runs 0→2 so the AI's registered request reflects the new mask.
  - Commit happens on the first cycle with settle == 2 and (`move_tick` or pending).
- Commit rule:
  - If the request is one-hot and `request & validDirection` ≠ 0, move in the requested direction and set `GhostDirActual` to the request.
  - Otherwise, if `GhostDirActual & validDirection` ≠ 0, continue in `GhostDirActual`.
  - Otherwise, do not move and set `GhostDirActual` to 0.
- After commit: `dir_valid` and `validDirection` go to 0, pending is cleared, and the state returns to SCAN.
- `move_tick` while in SCAN, or in WAIT before settle, sets pending. Multiple ticks collapse into one move.
- A tick in the same cycle as a commit is absorbed by that commit.
- Coordinate arithmetic is 5-bit. Edge behaviour is set by the configuration macro.
- Asserting reset mid-scan or mid-commit returns all state to reset values immediately. Any in-flight `maze_wall` response is discarded.

## Timing
- Cycle 0 is the first edge after reset deasserts.
- `maze_rd_en` is high during cycles 0–3, with addresses for left, right, up, down in that order.
- `validDirection` and `dir_valid` are valid from cycle 5.
- Earliest commit is cycle 7. The new position is visible at cycle 8.
- A full step is therefore at least 8 cycles. With 25 MHz and a `move_tick` rate at or below 1 MHz, no ticks are lost.
- `GhostPosition_*` and `GhostDirActual` change only on a commit edge.

## Configuration
- `GHOST_TUNNEL_WRAP_EN` defined: neighbour and position coordinates wrap modulo 32 (x 31 + right → 0; x 0 + left → 31), forming the side tunnel.
- `GHOST_TUNNEL_WRAP_EN` undefined: a neighbour outside 0..31 is reported blocked.
  - The read is still issued, so SCAN timing is unchanged.
  - The returned `maze_wall` value for that neighbour is ignored.

## Structure
- Package `ghost_pkg` holds:
  - the direction constants `DIR_LEFT`, `DIR_RIGHT`, `DIR_UP`, `DIR_DOWN`;
  - the state enum (SCAN, WAIT);
  - the grid coordinate width (5).
- Sub-module `ghost_maze_scan` contains the read sequencer, neighbour address generation (including edge/wrap handling) and mask assembly. It returns the mask plus a `done` pulse.
- The top level holds the WAIT/commit state machine and the position registers.

## Test plan
- Open maze (all `maze_wall` = 0), start (13,11): reads at (12,11), (14,11), (13,10), (13,12) on cycles 0–3; `validDirection` = 1111 and `dir_valid` = 1 at cycle 5.
- Request 0010 with `move_tick` at cycle 7: position (14,11) and `GhostDirActual` = 0010 at cycle 8; `dir_valid` = 0; next scan starts.
- Wall on the right, request 0010, `GhostDirActual` = 0100 with up open: y decrements by 1 and `GhostDirActual` stays 0100.
- Walls on all four sides with any request: position unchanged and `GhostDirActual` = 0000.
- Ghost at x = 31 requesting right: with the macro, x becomes 0; without it, `validDirection[1]` = 0 and x stays 31.
- Two `move_tick` pulses during SCAN, then reset asserted mid-scan: a single move occurs before reset; after reset, position = (13,11) and all outputs hold their reset values.
